cnn_split_2out_new: RTL and testbench

//  Splits one channel-concatenated pixel stream back into two streams; inverse of the two-input concat.

---
 rtl/cnn_split_2out_new.sv | 90 +++++++++
 tb/tb_cnn_split_2out_new.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/cnn_split_2out_new.sv
// cnn_split_2out_new: splits a channel-concatenated pixel stream into two branch streams.
// Each frame carries SIZE_NO1 branch-1 words followed by SIZE_NO2 branch-2 words.
// One registered stage, no backpressure; frame_done marks the last branch-2 word.
module cnn_split_2out_new #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned SIZE_NO1   = 612 * 612,
  parameter int unsigned SIZE_NO2   = 612 * 612
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] in,
  output logic [DATA_WIDTH-1:0] out_no1,
  output logic                  valid_out_no1,
  output logic [DATA_WIDTH-1:0] out_no2,
  output logic                  valid_out_no2,
  output logic                  frame_done
);

  localparam int unsigned MAX_SIZE  = (SIZE_NO1 > SIZE_NO2) ? SIZE_NO1 : SIZE_NO2;
  localparam int unsigned CNT_WIDTH = (MAX_SIZE > 1) ? $clog2(MAX_SIZE) : 1;
  localparam logic [CNT_WIDTH-1:0] LAST_NO1 = CNT_WIDTH'(SIZE_NO1 - 1);
  localparam logic [CNT_WIDTH-1:0] LAST_NO2 = CNT_WIDTH'(SIZE_NO2 - 1);

  typedef enum logic {
    S_NO1 = 1'b0,
    S_NO2 = 1'b1
  } state_t;

  state_t                r_state;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic [DATA_WIDTH-1:0] r_out_no1;
  logic [DATA_WIDTH-1:0] r_out_no2;
  logic                  r_valid_no1;
  logic                  r_valid_no2;
  logic                  r_frame_done;

  // Route each valid word to the branch selected by the state; counter tracks position within branch.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_NO1;
      r_cnt        <= '0;
      r_out_no1    <= '0;
      r_out_no2    <= '0;
      r_valid_no1  <= 1'b0;
      r_valid_no2  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_valid_no1  <= 1'b0;
      r_valid_no2  <= 1'b0;
      r_frame_done <= 1'b0;
      if (valid_in) begin
        case (r_state)
          S_NO1: begin
            r_out_no1   <= in;
            r_valid_no1 <= 1'b1;
            if (r_cnt == LAST_NO1) begin
              r_cnt   <= '0;
              r_state <= S_NO2;
            end else begin
              r_cnt <= r_cnt + CNT_WIDTH'(1);
            end
          end
          S_NO2: begin
            r_out_no2   <= in;
            r_valid_no2 <= 1'b1;
            if (r_cnt == LAST_NO2) begin
              r_cnt        <= '0;
              r_state      <= S_NO1;
              r_frame_done <= 1'b1;
            end else begin
              r_cnt <= r_cnt + CNT_WIDTH'(1);
            end
          end
          default: begin
            r_cnt   <= '0;
            r_state <= S_NO1;
          end
        endcase
      end
    end
  end

  assign out_no1       = r_out_no1;
  assign out_no2       = r_out_no2;
  assign valid_out_no1 = r_valid_no1;
  assign valid_out_no2 = r_valid_no2;
  assign frame_done    = r_frame_done;

endmodule

// File: tb/tb_cnn_split_2out_new.sv
// Directed bench for cnn_split_2out_new: a 4/3 split instance and a 1/1 split instance.
module tb_cnn_split_2out_new;

  logic        clk;
  logic        reset_a, reset_b;
  logic        vin_a, vin_b;
  logic [31:0] in_a, in_b;
  logic [31:0] o1_a, o2_a, o1_b, o2_b;
  logic        v1_a, v2_a, fd_a, v1_b, v2_b, fd_b;

  int n_checks;
  int n_err;

  // Bench-side expected values for instance A (hold tracking for data registers)
  logic [31:0] e_o1, e_o2;

  cnn_split_2out_new #(.DATA_WIDTH(32), .SIZE_NO1(4), .SIZE_NO2(3)) u_dut_a (
    .clk(clk), .reset(reset_a), .valid_in(vin_a), .in(in_a),
    .out_no1(o1_a), .valid_out_no1(v1_a), .out_no2(o2_a), .valid_out_no2(v2_a),
    .frame_done(fd_a)
  );

  cnn_split_2out_new #(.DATA_WIDTH(32), .SIZE_NO1(1), .SIZE_NO2(1)) u_dut_b (
    .clk(clk), .reset(reset_b), .valid_in(vin_b), .in(in_b),
    .out_no1(o1_b), .valid_out_no1(v1_b), .out_no2(o2_b), .valid_out_no2(v2_b),
    .frame_done(fd_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle on A; idx is the word's position in the 4+3 frame (ignored when v=0)
  task automatic send_a(input string tag, input logic v, input logic [31:0] d, input int idx);
    logic ev1, ev2, efd;
    @(negedge clk);
    vin_a = v;
    in_a  = d;
    @(posedge clk);
    #1;
    ev1 = 1'b0; ev2 = 1'b0; efd = 1'b0;
    if (v) begin
      if (idx < 4) begin
        ev1  = 1'b1;
        e_o1 = d;
      end else begin
        ev2  = 1'b1;
        e_o2 = d;
        efd  = (idx == 6);
      end
    end
    chk({tag, ".v1"}, 32'(v1_a), 32'(ev1));
    chk({tag, ".v2"}, 32'(v2_a), 32'(ev2));
    chk({tag, ".fd"}, 32'(fd_a), 32'(efd));
    chk({tag, ".o1"}, o1_a, e_o1);
    chk({tag, ".o2"}, o2_a, e_o2);
  endtask

  // Synchronous reset on A, optionally with a concurrent valid word that must be dropped
  task automatic reset_cycle_a(input string tag, input logic v, input logic [31:0] d);
    @(negedge clk);
    reset_a = 1'b1;
    vin_a   = v;
    in_a    = d;
    @(posedge clk);
    #1;
    e_o1 = 32'h0;
    e_o2 = 32'h0;
    chk({tag, ".v1"}, 32'(v1_a), 32'h0);
    chk({tag, ".v2"}, 32'(v2_a), 32'h0);
    chk({tag, ".fd"}, 32'(fd_a), 32'h0);
    chk({tag, ".o1"}, o1_a, 32'h0);
    chk({tag, ".o2"}, o2_a, 32'h0);
    @(negedge clk);
    reset_a = 1'b0;
    vin_a   = 1'b0;
  endtask

  task automatic send_b(input string tag, input logic [31:0] d, input logic ev1, input logic ev2,
                        input logic [31:0] eo1, input logic [31:0] eo2, input logic efd);
    @(negedge clk);
    vin_b = 1'b1;
    in_b  = d;
    @(posedge clk);
    #1;
    chk({tag, ".v1"}, 32'(v1_b), 32'(ev1));
    chk({tag, ".v2"}, 32'(v2_b), 32'(ev2));
    chk({tag, ".fd"}, 32'(fd_b), 32'(efd));
    chk({tag, ".o1"}, o1_b, eo1);
    chk({tag, ".o2"}, o2_b, eo2);
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    e_o1     = 32'h0;
    e_o2     = 32'h0;
    reset_a  = 1'b1;
    reset_b  = 1'b1;
    vin_a    = 1'b0;
    vin_b    = 1'b0;
    in_a     = 32'h0;
    in_b     = 32'h0;

    // Reset state of both instances
    @(posedge clk);
    #1;
    chk("rst.a.o1", o1_a, 32'h0);
    chk("rst.a.o2", o2_a, 32'h0);
    chk("rst.a.v1", 32'(v1_a), 32'h0);
    chk("rst.a.v2", 32'(v2_a), 32'h0);
    chk("rst.a.fd", 32'(fd_a), 32'h0);
    chk("rst.b.o1", o1_b, 32'h0);
    chk("rst.b.v2", 32'(v2_b), 32'h0);
    @(negedge clk);
    reset_a = 1'b0;
    reset_b = 1'b0;

    // T1: one frame 1..7, continuous valid
    for (int i = 1; i <= 7; i++) send_a($sformatf("t1.w%0d", i), 1'b1, 32'(i), i - 1);

    // T2: second frame 8..14 back-to-back with no bubble
    for (int i = 8; i <= 14; i++) send_a($sformatf("t2.w%0d", i), 1'b1, 32'(i), i - 8);

    // T3: valid toggling 1010.. over words 1..7; gap cycles carry junk that must be ignored
    for (int i = 1; i <= 7; i++) begin
      send_a($sformatf("t3.w%0d", i), 1'b1, 32'(i), i - 1);
      send_a($sformatf("t3.gap%0d", i), 1'b0, 32'hDEAD_0000 + 32'(i), 0);
    end

    // T4: reset after word 5 (inside branch 2), then a clean frame routes as T1
    for (int i = 1; i <= 5; i++) send_a($sformatf("t4.pre%0d", i), 1'b1, 32'(i), i - 1);
    reset_cycle_a("t4.rst", 1'b0, 32'h0);
    for (int i = 1; i <= 7; i++) send_a($sformatf("t4.w%0d", i), 1'b1, 32'(i), i - 1);

    // T6: reset with valid_in high drops the word; next word is branch-1 word 0
    send_a("t6.pre1", 1'b1, 32'h21, 0);
    send_a("t6.pre2", 1'b1, 32'h22, 1);
    reset_cycle_a("t6.rst", 1'b1, 32'h99);
    for (int i = 1; i <= 7; i++) send_a($sformatf("t6.w%0d", i), 1'b1, 32'h30 + 32'(i), i - 1);
    send_a("t6.idle", 1'b0, 32'h0, 0);

    // T5: SIZE_NO1=SIZE_NO2=1, words A,B,C,D alternate branches
    send_b("t5.A", 32'hA, 1'b1, 1'b0, 32'hA, 32'h0, 1'b0);
    send_b("t5.B", 32'hB, 1'b0, 1'b1, 32'hA, 32'hB, 1'b1);
    send_b("t5.C", 32'hC, 1'b1, 1'b0, 32'hC, 32'hB, 1'b0);
    send_b("t5.D", 32'hD, 1'b0, 1'b1, 32'hC, 32'hD, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
